// File: rtl/heichips25_fifo_echo.sv
// Byte echo FIFO for a tiny-project pin set: host pushes bytes, optionally inverted,
// and pops them back in order; an XOR checksum is shown whenever the FIFO is empty.
module heichips25_fifo_echo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned AddrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH) + 1;
  localparam logic [CountW-1:0] CountFull = CountW'(DEPTH);

  // Storage and control state
  logic [7:0]        mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [7:0]        csum_q, csum_d;
  logic              error_q, error_d;

  // Decoded host controls
  logic       push_req, pop_req, clr_req, inv_mode;
  logic       not_empty, full;
  logic       pop_acc, push_acc;
  logic [7:0] wdata;
  logic       unused_uio_hi;

  assign push_req      = uio_in[0];
  assign pop_req       = uio_in[1];
  assign clr_req       = uio_in[2];
  assign inv_mode      = uio_in[3];
  assign unused_uio_hi = ^uio_in[7:4];

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CountFull);
  assign wdata     = inv_mode ? ~ui_in : ui_in;

  // A pop frees the slot a same-cycle push needs, so full + push + pop is legal.
  assign pop_acc  = ena && !clr_req && pop_req && not_empty;
  assign push_acc = ena && !clr_req && push_req && (!full || pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    csum_d   = csum_q;
    error_d  = error_q;

    if (ena) begin
      if (clr_req) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        csum_d   = '0;
        error_d  = 1'b0;
      end else begin
        if (push_acc) begin
          wr_ptr_d = wr_ptr_q + AddrW'(1);
          csum_d   = csum_q ^ wdata;
        end
        if (pop_acc) begin
          rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        unique case ({push_acc, pop_acc})
          2'b10:   count_d = count_q + CountW'(1);
          2'b01:   count_d = count_q - CountW'(1);
          default: count_d = count_q;
        endcase
        if (push_req && !push_acc) begin
          error_d = 1'b1;
        end
        if (pop_req && !not_empty) begin
          error_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      csum_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      csum_q   <= csum_d;
      error_q  <= error_d;
    end
  end

  // Memory contents need no reset; stale entries are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (rst_n && push_acc) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    uo_out  = not_empty ? mem_q[rd_ptr_q] : csum_q;
    uio_out = {^uo_out, error_q, full, not_empty, 4'h0};
    uio_oe  = 8'hF0;
  end

endmodule

// File: tb/tb_heichips25_fifo_echo.sv
// Directed table-driven bench for heichips25_fifo_echo (DEPTH=4), with a few
// hand-written sequences for simultaneous push/pop on empty and enable hold.
module tb_heichips25_fifo_echo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  heichips25_fifo_echo #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  // uio_in encodings
  localparam logic [7:0] Nop  = 8'h00;
  localparam logic [7:0] Push = 8'h01;
  localparam logic [7:0] Pop  = 8'h02;
  localparam logic [7:0] Clr  = 8'h04;
  localparam logic [7:0] Inv  = 8'h08;

  task automatic add(input string n, input logic r, input logic e, input logic [7:0] ui,
                     input logic [7:0] uio, input logic [7:0] euo, input logic [7:0] euio);
    vec_t v;
    v.name = n; v.rst_n = r; v.ena = e; v.ui = ui; v.uio = uio;
    v.exp_uo = euo; v.exp_uio = euio;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n  = v.rst_n;
    ena    = v.ena;
    ui_in  = v.ui;
    uio_in = v.uio;
    @(posedge clk);
    #1;
    check({v.name, " uo_out"}, uo_out, v.exp_uo);
    check({v.name, " uio_out"}, uio_out, v.exp_uio);
    check({v.name, " uio_oe"}, uio_oe, 8'hF0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;

    // name, rst_n, ena, ui, uio, exp uo_out, exp uio_out
    add("rst0",        0, 1, 8'h77, Push,       8'h00, 8'h00);
    add("rst1",        0, 1, 8'h77, Push,       8'h00, 8'h00);
    add("echo push12", 1, 1, 8'h12, Push,       8'h12, 8'h10);
    add("echo push34", 1, 1, 8'h34, Push,       8'h12, 8'h10);
    add("echo pop1",   1, 1, 8'h00, Pop,        8'h34, 8'h90);
    add("echo pop2",   1, 1, 8'h00, Pop,        8'h26, 8'h80);
    add("clr a",       1, 1, 8'h00, Clr,        8'h00, 8'h00);
    add("ovf push01",  1, 1, 8'h01, Push,       8'h01, 8'h90);
    add("ovf push02",  1, 1, 8'h02, Push,       8'h01, 8'h90);
    add("ovf push03",  1, 1, 8'h03, Push,       8'h01, 8'h90);
    add("ovf push04",  1, 1, 8'h04, Push,       8'h01, 8'hB0);
    add("ovf push05",  1, 1, 8'h05, Push,       8'h01, 8'hF0);
    add("ovf pop1",    1, 1, 8'h00, Pop,        8'h02, 8'hD0);
    add("ovf pop2",    1, 1, 8'h00, Pop,        8'h03, 8'h50);
    add("ovf pop3",    1, 1, 8'h00, Pop,        8'h04, 8'hD0);
    add("ovf pop4",    1, 1, 8'h00, Pop,        8'h04, 8'hC0);
    add("clr b",       1, 1, 8'h00, Clr,        8'h00, 8'h00);
    add("pp push01",   1, 1, 8'h01, Push,       8'h01, 8'h90);
    add("pp push02",   1, 1, 8'h02, Push,       8'h01, 8'h90);
    add("pp push03",   1, 1, 8'h03, Push,       8'h01, 8'h90);
    add("pp push04",   1, 1, 8'h04, Push,       8'h01, 8'hB0);
    add("pp pushpop",  1, 1, 8'hAA, Push | Pop, 8'h02, 8'hB0);
    add("pp pop1",     1, 1, 8'h00, Pop,        8'h03, 8'h10);
    add("pp pop2",     1, 1, 8'h00, Pop,        8'h04, 8'h90);
    add("pp pop3",     1, 1, 8'h00, Pop,        8'hAA, 8'h10);
    add("pp pop4",     1, 1, 8'h00, Pop,        8'hAE, 8'h80);
    add("clr c",       1, 1, 8'h00, Clr,        8'h00, 8'h00);
    add("inv push0F",  1, 1, 8'h0F, Push | Inv, 8'hF0, 8'h10);
    add("inv pop",     1, 1, 8'h00, Pop,        8'hF0, 8'h00);
    add("underflow",   1, 1, 8'h00, Pop,        8'hF0, 8'h40);
    add("err push11",  1, 1, 8'h11, Push,       8'h11, 8'h50);
    add("clr+push55",  1, 1, 8'h55, Push | Clr, 8'h00, 8'h00);
    add("ena0 push",   1, 0, 8'h66, Push,       8'h00, 8'h00);
    add("push66",      1, 1, 8'h66, Push,       8'h66, 8'h10);
    add("ena0 pop",    1, 0, 8'h00, Pop,        8'h66, 8'h10);
    add("ena0 clr",    1, 0, 8'h00, Clr,        8'h66, 8'h10);
    add("mid rst",     0, 0, 8'h77, Push,       8'h00, 8'h00);
    add("post push3C", 1, 1, 8'h3C, Push,       8'h3C, 8'h10);
    add("post pop",    1, 1, 8'h00, Pop,        8'h3C, 8'h00);

    foreach (vecs[i]) apply(vecs[i]);

    // Push and pop together on empty: pop rejected (error), push still lands.
    v.name = "clr d";  v.rst_n = 1; v.ena = 1; v.ui = 8'h00; v.uio = Clr;
    v.exp_uo = 8'h00; v.exp_uio = 8'h00;
    apply(v);
    v.name = "empty pushpop"; v.ui = 8'h5A; v.uio = Push | Pop;
    v.exp_uo = 8'h5A; v.exp_uio = 8'h50;
    apply(v);

    // Several disabled cycles with assorted controls must not disturb anything.
    for (int k = 0; k < 4; k++) begin
      v.name = "hold"; v.ena = 0; v.ui = 8'(8'hC3 + k);
      v.uio = 8'(k + 1) | Inv;
      v.exp_uo = 8'h5A; v.exp_uio = 8'h50;
      apply(v);
    end

    // Reset overrides a disabled block.
    v.name = "rst ena0"; v.rst_n = 0; v.ena = 0; v.ui = 8'h00; v.uio = Clr;
    v.exp_uo = 8'h00; v.exp_uio = 8'h00;
    apply(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
